// File: rtl/read32_result_source_if.sv
// rtl/read32_result_source_if.sv - result stream, frame control and host read-side signals
interface read32_result_source_if #(
  parameter int DEPTH_LOG2 = 9,
  parameter int LEN_W      = 20
);
  logic [7:0]            res_data;
  logic                  res_valid;
  logic                  res_ready;
  logic [LEN_W-1:0]      frame_len;
  logic                  user_r_read_32_open;
  logic                  user_r_read_32_rden;
  logic [31:0]           user_r_read_32_data;
  logic                  user_r_read_32_empty;
  logic                  user_r_read_32_eof;
  logic                  frame_done;
  logic [DEPTH_LOG2:0]   fill_level;

  modport master (
    output res_data, res_valid, frame_len, user_r_read_32_open, user_r_read_32_rden,
    input  res_ready, user_r_read_32_data, user_r_read_32_empty, user_r_read_32_eof,
    input  frame_done, fill_level
  );

  modport slave (
    input  res_data, res_valid, frame_len, user_r_read_32_open, user_r_read_32_rden,
    output res_ready, user_r_read_32_data, user_r_read_32_empty, user_r_read_32_eof,
    output frame_done, fill_level
  );
endinterface

// File: rtl/read32_result_source.sv
// rtl/read32_result_source.sv - packs result bytes 4 per word into a FIFO read by the host
module read32_result_source #(
  parameter int DEPTH_LOG2 = 9,
  parameter int LEN_W      = 20
) (
  input  logic                     bus_clk,
  input  logic                     bus_rst_n,
  read32_result_source_if.slave    bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_OCC = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

  state_t                state;
  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic [DEPTH_LOG2:0]   occ;
  logic [LEN_W-1:0]      len_q, byte_cnt;
  logic [1:0]            lane;
  logic [23:0]           pack;
  logic                  open_q;
  logic [31:0]           rd_q;
  logic                  done_q;

  logic        open, full, empty, accept, last_byte, push, pop;
  logic [31:0] push_word;

  assign open      = bus.user_r_read_32_open;
  assign full      = (occ == FULL_OCC);
  assign empty     = (occ == '0);
  assign bus.res_ready = (state == STREAM) && !full && open;
  assign accept    = bus.res_valid && bus.res_ready;
  assign last_byte = ((byte_cnt + LEN_W'(1)) == len_q);
  assign pop       = bus.user_r_read_32_rden && !empty;

  always_comb begin
    push      = 1'b0;
    push_word = {bus.res_data, pack};
    if (accept && lane == 2'd3) begin
      push = 1'b1;
    end else if (state == FLUSH && !full) begin
      push      = 1'b1;
      push_word = {8'h00, pack};
    end
  end

  // Storage array has no reset so it can map onto block RAM.
  always_ff @(posedge bus_clk) begin
    if (push) mem[wptr] <= push_word;
  end

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      state    <= IDLE;
      wptr     <= '0;
      rptr     <= '0;
      occ      <= '0;
      len_q    <= '0;
      byte_cnt <= '0;
      lane     <= '0;
      pack     <= '0;
      open_q   <= 1'b0;
      rd_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      open_q <= open;
      done_q <= 1'b0;
      if (pop) rd_q <= mem[rptr];
      if (!open) begin
        // Closing the device discards everything buffered for the current frame.
        state    <= IDLE;
        wptr     <= '0;
        rptr     <= '0;
        occ      <= '0;
        byte_cnt <= '0;
        lane     <= '0;
        pack     <= '0;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop)  rptr <= rptr + 1'b1;
        case ({push, pop})
          2'b10:   occ <= occ + 1'b1;
          2'b01:   occ <= occ - 1'b1;
          default: occ <= occ;
        endcase
        case (state)
          IDLE: begin
            if (!open_q) begin
              len_q    <= bus.frame_len;
              byte_cnt <= '0;
              lane     <= '0;
              pack     <= '0;
              if (bus.frame_len == '0) begin
                state  <= DONE;
                done_q <= 1'b1;
              end else begin
                state <= STREAM;
              end
            end
          end
          STREAM: begin
            if (accept) begin
              byte_cnt <= byte_cnt + LEN_W'(1);
              lane     <= lane + 2'd1;
              case (lane)
                2'd0:    pack[7:0]   <= bus.res_data;
                2'd1:    pack[15:8]  <= bus.res_data;
                2'd2:    pack[23:16] <= bus.res_data;
                default: pack        <= '0;
              endcase
              if (last_byte) begin
                if (lane == 2'd3) begin
                  state  <= DONE;
                  done_q <= 1'b1;
                end else begin
                  state <= FLUSH;
                end
              end
            end
          end
          FLUSH: begin
            if (!full) begin
              pack   <= '0;
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.user_r_read_32_data  = rd_q;
  assign bus.user_r_read_32_empty = empty;
  assign bus.user_r_read_32_eof   = (state == DONE) && empty;
  assign bus.frame_done           = done_q;
  assign bus.fill_level           = occ;
endmodule
